// File: rtl/uart_rx_fsm.sv
// UART RX sequencer: start detection, oversample/bit counters, checker strobes,
// and one-cycle frame qualification (data_valid / frame_err). All outputs registered.
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [2:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  parity_check_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

    state_t                r_state;
    logic [PRESCALE_W-1:0] r_p;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [2:0]            r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_sticky;
    logic                  r_dat_samp_en, r_deser_en, r_strt_chk_en, r_parity_check_en;
    logic                  r_stp_chk_en, r_data_valid, r_frame_err, r_busy;

    logic                  w_last;
    logic                  w_pre;
    logic [PRESCALE_W-1:0] w_p_in;

    assign w_last = (r_edge_cnt == r_p - PRESCALE_W'(1));
    // Strobes are registered, so they are set one cycle early to land on edge P-2.
    assign w_pre  = (r_edge_cnt == r_p - PRESCALE_W'(3));
    assign w_p_in = (prescale < P_MIN) ? P_MIN : prescale;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_p               <= '0;
            r_edge_cnt        <= '0;
            r_bit_cnt         <= '0;
            r_par_en          <= 1'b0;
            r_par_sticky      <= 1'b0;
            r_dat_samp_en     <= 1'b0;
            r_deser_en        <= 1'b0;
            r_strt_chk_en     <= 1'b0;
            r_parity_check_en <= 1'b0;
            r_stp_chk_en      <= 1'b0;
            r_data_valid      <= 1'b0;
            r_frame_err       <= 1'b0;
            r_busy            <= 1'b0;
        end else begin
            r_deser_en        <= 1'b0;
            r_strt_chk_en     <= 1'b0;
            r_parity_check_en <= 1'b0;
            r_stp_chk_en      <= 1'b0;
            r_data_valid      <= 1'b0;
            r_frame_err       <= 1'b0;
            if (r_state == S_IDLE) begin
                r_edge_cnt <= '0;
                if (!RX_IN) begin
                    r_state       <= S_START;
                    r_p           <= w_p_in;
                    r_par_en      <= PAR_EN;
                    r_busy        <= 1'b1;
                    r_dat_samp_en <= 1'b1;
                end
            end else begin
                r_edge_cnt <= w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);
                case (r_state)
                    S_START: begin
                        r_strt_chk_en <= w_pre;
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            if (strt_glitch) begin
                                r_state       <= S_IDLE;
                                r_busy        <= 1'b0;
                                r_dat_samp_en <= 1'b0;
                                r_par_sticky  <= 1'b0;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        r_deser_en <= w_pre;
                        if (w_last) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= '0;
                                r_state   <= r_par_en ? S_PARITY : S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        r_parity_check_en <= w_pre;
                        if (w_last) begin
                            r_par_sticky <= par_err;
                            r_state      <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        r_stp_chk_en <= w_pre;
                        if (w_last) begin
                            r_state       <= S_IDLE;
                            r_busy        <= 1'b0;
                            r_dat_samp_en <= 1'b0;
                            r_par_sticky  <= 1'b0;
                            r_data_valid  <= !stp_err && !r_par_sticky;
                            r_frame_err   <= stp_err || r_par_sticky;
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_dat_samp_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign edge_cnt        = r_edge_cnt;
    assign bit_cnt         = r_bit_cnt;
    assign dat_samp_en     = r_dat_samp_en;
    assign deser_en        = r_deser_en;
    assign strt_chk_en     = r_strt_chk_en;
    assign parity_check_en = r_parity_check_en;
    assign stp_chk_en      = r_stp_chk_en;
    assign data_valid      = r_data_valid;
    assign frame_err       = r_frame_err;
    assign busy            = r_busy;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame timing, checker strobes, error paths,
// back-to-back frames and mid-frame reset, checked by immediate assertions.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic       strt_glitch, par_err, stp_err;
    logic [5:0] edge_cnt;
    logic [2:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, parity_check_en, stp_chk_en;
    logic       data_valid, frame_err, busy;

    int tests = 0;
    int fails = 0;

    int a_ec [0:255];
    int a_bc [0:255];
    bit a_de [0:255];
    bit a_sc [0:255];
    bit a_pc [0:255];
    bit a_st [0:255];
    bit a_bz [0:255];
    bit a_any[0:255];
    int n_dv, n_fe, n_de, n_pc, n_busy, n_both, dv1, dv2, fe1;

    uart_rx_fsm #(.PRESCALE_W(6)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .parity_check_en(parity_check_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0d, required %0d", tag, obs, exp);
            $error("%s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle 0 drives the start; inputs set in cycle c act on the edge ending c.
    task automatic run(input int pin, input int pchg, input int p, input bit pe,
                       input bit g, input bit perr, input bit serr,
                       input int rx2, input int rst_at, input int ncyc);
        n_dv = 0; n_fe = 0; n_de = 0; n_pc = 0; n_busy = 0; n_both = 0;
        dv1 = -1; dv2 = -1; fe1 = -1;
        for (int c = 0; c <= ncyc; c++) begin
            a_ec[c] = int'(edge_cnt);
            a_bc[c] = int'(bit_cnt);
            a_de[c] = deser_en;
            a_sc[c] = strt_chk_en;
            a_pc[c] = parity_check_en;
            a_st[c] = stp_chk_en;
            a_bz[c] = busy;
            a_any[c] = (edge_cnt != 0) || (bit_cnt != 0) || dat_samp_en || deser_en ||
                       strt_chk_en || parity_check_en || stp_chk_en || data_valid ||
                       frame_err || busy;
            if (data_valid) begin
                n_dv++;
                if (dv1 < 0) dv1 = c; else dv2 = c;
            end
            if (frame_err) begin
                n_fe++;
                if (fe1 < 0) fe1 = c;
            end
            if (data_valid && frame_err) n_both++;
            if (deser_en) n_de++;
            if (parity_check_en) n_pc++;
            if (busy) n_busy++;
            RX_IN       = !(c == 0 || c == rx2);
            prescale    = (c == 0 || c == rx2) ? 6'(pin) : 6'(pchg);
            PAR_EN      = (c == 0 || c == rx2) ? pe : !pe;
            strt_glitch = g && (c == p);
            par_err     = perr && (c == 10 * p);
            stp_err     = serr && (c == (pe ? 11 : 10) * p);
            rst         = !(c == rst_at);
            step();
        end
        RX_IN = 1'b1; rst = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    endtask

    initial begin
        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        step(); step(); step();
        chk("reset_outputs", int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
            parity_check_en, stp_chk_en, data_valid, frame_err, busy}), 0);
        rst = 1'b1;
        step(); step();
        chk("idle_busy", int'(busy), 0);

        // Clean frame P=8 with parity; prescale/PAR_EN wiggle mid-frame
        run(8, 32, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 95);
        chk("clean_dv_cycle", dv1, 89);
        chk("clean_dv_count", n_dv, 1);
        chk("clean_fe_count", n_fe, 0);
        chk("clean_deser_cnt", n_de, 8);
        chk("clean_par_cnt", n_pc, 1);
        chk("clean_par_cycle", int'(a_pc[79]), 1);
        chk("clean_strt_chk", int'(a_sc[7]), 1);
        chk("clean_deser_b0", int'(a_de[15]), 1);
        chk("clean_deser_b7", int'(a_de[71]), 1);
        chk("clean_stp_chk", int'(a_st[87]), 1);
        chk("clean_edge_first", a_ec[1], 0);
        chk("clean_edge_last", a_ec[8], 7);
        chk("clean_bitcnt_b3", a_bc[33], 3);
        chk("clean_busy_first", int'(a_bz[1]), 1);
        chk("clean_busy_last", int'(a_bz[88]), 1);
        chk("clean_busy_after", int'(a_bz[89]), 0);
        chk("clean_busy_len", n_busy, 88);

        // No parity, P=16
        run(16, 8, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 170);
        chk("nopar_dv_cycle", dv1, 161);
        chk("nopar_par_cnt", n_pc, 0);
        chk("nopar_deser_cnt", n_de, 8);
        chk("nopar_deser_b0", int'(a_de[31]), 1);

        // Start glitch
        run(8, 8, 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1, 100);
        chk("glitch_busy_t9", int'(a_bz[9]), 0);
        chk("glitch_busy_t8", int'(a_bz[8]), 1);
        chk("glitch_deser_cnt", n_de, 0);
        chk("glitch_dv_cnt", n_dv, 0);
        chk("glitch_fe_cnt", n_fe, 0);

        // Parity error
        run(8, 8, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 95);
        chk("parerr_fe_cycle", fe1, 89);
        chk("parerr_fe_cnt", n_fe, 1);
        chk("parerr_dv_cnt", n_dv, 0);

        // Stop error
        run(8, 8, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 95);
        chk("stperr_fe_cycle", fe1, 89);
        chk("stperr_dv_cnt", n_dv, 0);

        // Sticky flag must not leak into the next frame
        run(8, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 95);
        chk("after_err_dv", dv1, 89);
        chk("after_err_fe", n_fe, 0);

        // Back-to-back frames
        run(8, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, 89, -1, 185);
        chk("b2b_dv1", dv1, 89);
        chk("b2b_dv2", dv2, 178);
        chk("b2b_dv_cnt", n_dv, 2);
        chk("b2b_busy_t90", int'(a_bz[90]), 1);
        chk("b2b_deser_cnt", n_de, 16);

        // Reset mid-frame
        run(8, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 40, 100);
        chk("rst_busy_t40", int'(a_bz[40]), 1);
        chk("rst_outputs_t41", int'(a_any[41]), 0);
        chk("rst_dv_cnt", n_dv, 0);
        chk("rst_fe_cnt", n_fe, 0);
        run(8, 8, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 95);
        chk("post_rst_dv", dv1, 89);

        // prescale below 8 clamps to 8
        run(4, 4, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 95);
        chk("clamp_dv_cycle", dv1, 89);
        chk("clamp_edge_last", a_ec[8], 7);
        chk("never_both", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side sequencer for the UART RX path. It detects a start condition on the serial line and runs the oversampling edge and bit counters. It drives the enable strobes for the data sampler, deserializer, start checker, parity checker and stop checker, then collects their error flags to qualify each frame with a one-cycle `data_valid` or error pulse. It sits between the RX line synchroniser and those datapath blocks.

## Interface
- `PRESCALE_W`, default 6: width of the `prescale` input and of `edge_cnt`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `RX_IN` in 1: synchronised serial line; idle high.
- `PAR_EN` in 1: 1 means the frame carries a parity bit.
- `prescale` in `PRESCALE_W`: oversampling ratio P (clk cycles per bit). Legal values 8, 16, 32.
- `strt_glitch` in 1: start checker result; registered, valid the cycle after `strt_chk_en`.
- `par_err` in 1: parity checker result; registered, valid the cycle after `parity_check_en`.
- `stp_err` in 1: stop checker result; registered, valid the cycle after `stp_chk_en`.
- `edge_cnt` out `PRESCALE_W`: oversample index within the current bit, 0..P-1.
- `bit_cnt` out 3: data bit index, 0..7.
- `dat_samp_en` out 1: sampler enable.
- `deser_en` out 1: deserializer shift strobe.
- `strt_chk_en` out 1: start-check strobe.
- `parity_check_en` out 1: parity-check strobe.
- `stp_chk_en` out 1: stop-check strobe.
- `data_valid` out 1: frame received clean; one-cycle pulse.
- `frame_err` out 1: frame failed parity or stop check; one-cycle pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `edge_cnt` holds 0 in IDLE. In every other state it increments each cycle and wraps from P-1 to 0.
- A bit period ends on the cycle with `edge_cnt == P-1`, called "last edge".
- P and PAR_EN are latched on the IDLE→START transition and held for the whole frame. A latched P below 8 is clamped to 8.
- Checker strobes pulse for one cycle at `edge_cnt == P-2`. The matching error input is read at the last edge.
- IDLE:
  - If `RX_IN == 0`, go to START. `edge_cnt` is 0 in the first START cycle.
  - Otherwise stay in IDLE.
- START:
  - Pulse `strt_chk_en` at P-2.
  - At the last edge: if `strt_glitch == 1`, go to IDLE with no other outputs.
  - At the last edge: otherwise go to DATA with `bit_cnt = 0`.
- DATA:
  - Pulse `deser_en` at P-2.
  - At the last edge, if `bit_cnt == 7`: go to PARITY when the latched PAR_EN is 1, else go to STOP. `bit_cnt` returns to 0.
  - At the last edge, otherwise: `bit_cnt` increments.
- PARITY:
  - Pulse `parity_check_en` at P-2.
  - At the last edge, latch `par_err` into an internal sticky flag and go to STOP.
- STOP:
  - Pulse `stp_chk_en` at P-2.
  - At the last edge, go to IDLE.
  - In the next cycle, pulse `data_valid` if both `stp_err` and the sticky flag are 0.
  - Otherwise pulse `frame_err` in that cycle.
  - The sticky flag clears on entry to IDLE.
- `dat_samp_en` is high in START, DATA, PARITY and STOP.
- `data_valid` and `frame_err` are never high together.
- Back-to-back frames: on the cycle `data_valid` or `frame_err` pulses, the block is already in IDLE. If `RX_IN` is low in that cycle, the next start is detected there.
- A `prescale` change mid-frame has no effect until the next start.
- Reset (`rst == 0` at a clock edge), whether idle or mid-frame:
  - State goes to IDLE.
  - Counters and the sticky flag go to 0.
  - All outputs are 0 from the following cycle.
  - No `data_valid` or `frame_err` is emitted for the aborted frame.

## Timing
- Reset values: `edge_cnt = 0`, `bit_cnt = 0`, and every strobe, `data_valid`, `frame_err` and `busy` equal to 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Let t0 be the cycle in which IDLE sees `RX_IN == 0`.
- START occupies cycles t0+1..t0+P.
- Data bit k occupies cycles t0+(k+1)P+1..t0+(k+2)P.
- With parity: PARITY occupies t0+9P+1..t0+10P and STOP occupies t0+10P+1..t0+11P. `data_valid` or `frame_err` pulses at t0+11P+1.
- Without parity: the result pulses at t0+10P+1.
- The `deser_en` pulse for bit k is at t0+(k+1)P+P-1.
- Each frame has exactly 8 `deser_en` pulses, and exactly 1 `parity_check_en` pulse when PAR_EN is 1.
- Start glitch: back in IDLE at t0+P+1.

## Test plan
- Clean frame: P=8, PAR_EN=1, checker errors 0. Expect `data_valid` at t0+89, 8 `deser_en` pulses, 1 `parity_check_en` pulse at t0+79, `busy` high for t0+1..t0+88.
- No parity: P=16, PAR_EN=0. Expect `data_valid` at t0+161 and 0 `parity_check_en` pulses.
- Start glitch: P=8, `strt_glitch=1` at t0+8. Expect IDLE at t0+9, 0 `deser_en` pulses, no `data_valid` or `frame_err`.
- Parity error: P=8, PAR_EN=1, `par_err=1` at t0+80. Expect `frame_err` at t0+89 and no `data_valid`. Repeat with `stp_err=1` at t0+88: same response.
- Back-to-back: two frames, P=8, PAR_EN=1, second start low at t0+89. Expect `data_valid` at t0+89 and t0+178.
- Reset mid-frame: `rst=0` at t0+40 during DATA. Expect all outputs 0 at t0+41 and no `data_valid` or `frame_err`. A following clean frame completes normally.
